// File: rtl/panda_pkg.sv
// Shared rename-stage constants and helpers: tag geometry, free-list depth, null tag.
package panda_pkg;

  localparam int TAG_W    = 7;
  localparam int NUM_PR   = 128;
  localparam int NUM_AR   = 32;
  localparam int FL_DEPTH = NUM_PR - NUM_AR;
  localparam int PTR_W    = 7;

  localparam logic [TAG_W-1:0] NULL_TAG = 7'h7f;

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [PTR_W-1:0] ptr_t;

  // Request counts are at most two per cycle; an encoded 3 behaves like 2.
  function automatic logic [1:0] clamp2(input logic [1:0] n);
    clamp2 = (n == 2'd3) ? 2'd2 : n;
  endfunction

endpackage

// File: rtl/fl_ptr_inc.sv
// Circular-list pointer advance by 0, 1 or 2, wrapping modulo FL_DEPTH (not a power of two).
module fl_ptr_inc
  import panda_pkg::*;
(
  input  logic [PTR_W-1:0] ptr,
  input  logic [1:0]       inc,
  output logic [PTR_W-1:0] ptr_next
);

  localparam logic [PTR_W:0] DEPTH_W = (PTR_W+1)'(FL_DEPTH);

  logic [PTR_W:0] sum;

  always_comb begin
    sum      = {1'b0, ptr} + {{(PTR_W-1){1'b0}}, inc};
    ptr_next = (sum >= DEPTH_W) ? PTR_W'(sum - DEPTH_W) : sum[PTR_W-1:0];
  end

endmodule

// File: rtl/free_list.sv
// Physical-register free list: circular FIFO handing out up to two tags and reclaiming up to two per cycle.
// Optional FL_RETIRE_BYPASS_EN forwards same-cycle retired tags to dispatch when the list runs short.
module free_list
  import panda_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       id_dispatch_num,
  input  logic [1:0]       rob_retire_num,
  input  logic [TAG_W-1:0] rob_retire_tag_a,
  input  logic [TAG_W-1:0] rob_retire_tag_b,
  output logic [TAG_W-1:0] fl_pr0,
  output logic [TAG_W-1:0] fl_pr1,
  output logic [1:0]       fl_cap,
  output logic [6:0]       fl_count,
  output logic             fl_overflow
);

  tag_t       list_q [FL_DEPTH];
  tag_t       list_d [FL_DEPTH];
  ptr_t       head_q, head_d, head_p1;
  ptr_t       tail_q, tail_d, tail_p1;
  logic [6:0] count_q, count_d;
  logic       overflow_q, overflow_d;

  logic [1:0] disp_n, ret_n, list_avail, cap;
  logic [1:0] alloc_n, from_list, byp_n, rem_n, acc_n;
  logic [7:0] space;
  tag_t       wtag0, wtag1, pr0, pr1;
  logic       we0, we1;
`ifdef FL_RETIRE_BYPASS_EN
  logic [2:0] cap_sum;
`endif

  fl_ptr_inc u_head_p1 (.ptr(head_q), .inc(2'd1),    .ptr_next(head_p1));
  fl_ptr_inc u_head_nx (.ptr(head_q), .inc(from_list), .ptr_next(head_d));
  fl_ptr_inc u_tail_p1 (.ptr(tail_q), .inc(2'd1),    .ptr_next(tail_p1));
  fl_ptr_inc u_tail_nx (.ptr(tail_q), .inc(acc_n),   .ptr_next(tail_d));

  always_comb begin
    disp_n     = clamp2(id_dispatch_num);
    ret_n      = clamp2(rob_retire_num);
    list_avail = (count_q >= 7'd2) ? 2'd2 : count_q[1:0];
`ifdef FL_RETIRE_BYPASS_EN
    cap_sum = {1'b0, list_avail} + {1'b0, ret_n};
    cap     = (cap_sum >= 3'd2) ? 2'd2 : cap_sum[1:0];
`else
    cap = list_avail;
`endif
    alloc_n   = (disp_n < cap) ? disp_n : cap;
    from_list = (alloc_n < list_avail) ? alloc_n : list_avail;
    // Grants beyond what the list holds are served by forwarded retire tags, oldest first.
    byp_n = alloc_n - from_list;
    rem_n = ret_n - byp_n;

    // Room left after this cycle's pops; tag_b is the first casualty when short.
    space      = 8'(FL_DEPTH) - {1'b0, count_q} + {6'd0, from_list};
    acc_n      = (space >= {6'd0, rem_n}) ? rem_n : space[1:0];
    overflow_d = overflow_q | (acc_n != rem_n);
    count_d    = count_q - {5'd0, from_list} + {5'd0, acc_n};

    wtag0 = (byp_n == 2'd0) ? rob_retire_tag_a : rob_retire_tag_b;
    wtag1 = rob_retire_tag_b;
    we0   = (acc_n != 2'd0);
    we1   = (acc_n == 2'd2);

    pr0 = NULL_TAG;
    pr1 = NULL_TAG;
    if (list_avail != 2'd0) pr0 = list_q[head_q];
    if (list_avail == 2'd2) pr1 = list_q[head_p1];
`ifdef FL_RETIRE_BYPASS_EN
    if (list_avail == 2'd0) begin
      if (ret_n != 2'd0) pr0 = rob_retire_tag_a;
      if (ret_n == 2'd2) pr1 = rob_retire_tag_b;
    end else if (list_avail == 2'd1 && ret_n != 2'd0) begin
      pr1 = rob_retire_tag_a;
    end
`endif

    for (int i = 0; i < FL_DEPTH; i++) begin
      list_d[i] = list_q[i];
      if (we0 && tail_q == PTR_W'(i))  list_d[i] = wtag0;
      if (we1 && tail_p1 == PTR_W'(i)) list_d[i] = wtag1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= 7'(FL_DEPTH);
      overflow_q <= 1'b0;
      for (int i = 0; i < FL_DEPTH; i++) begin
        list_q[i] <= TAG_W'(NUM_AR + i);
      end
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      list_q     <= list_d;
    end
  end

  assign fl_pr0      = pr0;
  assign fl_pr1      = pr1;
  assign fl_cap      = cap;
  assign fl_count    = count_q;
  assign fl_overflow = overflow_q;

endmodule

// File: tb/tb_free_list.sv
// Randomized scoreboard bench for free_list against a queue-based reference of the free pool.
module tb_free_list;
  import panda_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] id_dispatch_num, rob_retire_num;
  logic [6:0] rob_retire_tag_a, rob_retire_tag_b;
  logic [6:0] fl_pr0, fl_pr1, fl_count;
  logic [1:0] fl_cap;
  logic       fl_overflow;

  always #5 clock = ~clock;

  free_list dut (
    .clock(clock), .reset(reset),
    .id_dispatch_num(id_dispatch_num), .rob_retire_num(rob_retire_num),
    .rob_retire_tag_a(rob_retire_tag_a), .rob_retire_tag_b(rob_retire_tag_b),
    .fl_pr0(fl_pr0), .fl_pr1(fl_pr1), .fl_cap(fl_cap),
    .fl_count(fl_count), .fl_overflow(fl_overflow)
  );

  typedef struct packed {
    logic [6:0] pr0;
    logic [6:0] pr1;
    logic [1:0] cap;
    logic [6:0] count;
    logic       ovf;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_mis = 0;

  // Reference: the free pool as an ordered queue of tags plus a sticky drop flag.
  int fl[$];
  bit m_ovf;

  task automatic model_reset();
    fl.delete();
    for (int i = 0; i < 96; i++) fl.push_back(32 + i);
    m_ovf = 1'b0;
  endtask

  task automatic cycle(input bit rst, input int d, input int r, input int ta, input int tb);
    int   dn, rn, cap, a, dummy;
    int   rq[$];
    int   vis[$];
    exp_t e;
    @(posedge clock); #1;
    reset            = rst ? 1'b0 : 1'b1;
    id_dispatch_num  = 2'(d);
    rob_retire_num   = 2'(r);
    rob_retire_tag_a = (r >= 1) ? 7'(ta) : 7'h7f;
    rob_retire_tag_b = (r >= 2) ? 7'(tb) : 7'h7f;
    if (rst) begin
      model_reset();
      return;
    end
    dn = (d > 2) ? 2 : d;
    rn = (r > 2) ? 2 : r;
    if (rn >= 1) rq.push_back(ta);
    if (rn >= 2) rq.push_back(tb);
    vis = fl;
`ifdef FL_RETIRE_BYPASS_EN
    foreach (rq[k]) vis.push_back(rq[k]);
`endif
    cap     = (vis.size() >= 2) ? 2 : vis.size();
    e.pr0   = (cap >= 1) ? 7'(vis[0]) : 7'h7f;
    e.pr1   = (cap >= 2) ? 7'(vis[1]) : 7'h7f;
    e.cap   = 2'(cap);
    e.count = 7'(fl.size());
    e.ovf   = m_ovf;
    exp_q.push_back(e);
    a = (dn < cap) ? dn : cap;
    repeat (a) begin
      if (fl.size() > 0) dummy = fl.pop_front();
      else dummy = rq.pop_front();
    end
    foreach (rq[k]) begin
      if (fl.size() < 96) fl.push_back(rq[k]);
      else m_ovf = 1'b1;
    end
  endtask

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_vec++;
      if ({fl_pr0, fl_pr1, fl_cap, fl_count, fl_overflow} !== mon_e) begin
        n_mis++;
        $display("FAIL outputs vec %0d: got pr0=%0d pr1=%0d cap=%0d count=%0d ovf=%0d, expected pr0=%0d pr1=%0d cap=%0d count=%0d ovf=%0d",
                 n_vec, fl_pr0, fl_pr1, fl_cap, fl_count, fl_overflow,
                 mon_e.pr0, mon_e.pr1, mon_e.cap, mon_e.count, mon_e.ovf);
      end else begin
        $display("vec %0d ok: pr0=%0d pr1=%0d cap=%0d count=%0d ovf=%0d",
                 n_vec, fl_pr0, fl_pr1, fl_cap, fl_count, fl_overflow);
      end
    end
  end

  initial begin
    int d, r;
    reset = 1'b0;
    id_dispatch_num = '0; rob_retire_num = '0;
    rob_retire_tag_a = 7'h7f; rob_retire_tag_b = 7'h7f;
    model_reset();

    // Reset state, then drain completely and refill from empty.
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    repeat (48) cycle(0, 2, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 2, 2, 40, 41);
    cycle(0, 0, 0, 0, 0);

    // Free into a full list.
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 1, 5, 0);
    cycle(0, 0, 0, 0, 0);

    // Pointer wrap at the non-power-of-two boundary.
    cycle(1, 0, 0, 0, 0);
    repeat (95) cycle(0, 1, 0, 0, 0);
    repeat (95) cycle(0, 0, 1, $urandom_range(0, 126), 0);
    cycle(0, 2, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);

    // Single-entry list with a double request and one retire.
    cycle(1, 0, 0, 0, 0);
    repeat (47) cycle(0, 2, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 2, 1, 9, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 3, 3, 17, 18);
    cycle(0, 0, 0, 0, 0);

    // Random traffic in balanced, dispatch-heavy and retire-heavy phases.
    for (int i = 0; i < 3000; i++) begin
      case ((i / 300) % 3)
        0: begin d = $urandom_range(0, 3); r = $urandom_range(0, 3); end
        1: begin d = $urandom_range(1, 3); r = $urandom_range(0, 1); end
        default: begin d = $urandom_range(0, 1); r = $urandom_range(1, 3); end
      endcase
      cycle(($urandom_range(0, 299) == 0), d, r,
            $urandom_range(0, 126), $urandom_range(0, 126));
    end

    for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clock);
    #1;
    if (exp_q.size() > 0) begin
      n_mis++;
      $display("FAIL drain: %0d expectations pending, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
